// File: rtl/zap_branch_state_table_pkg.sv
// zap_branch_state_table_pkg
// Shared predictor definitions for the branch state table and predecode.
// Contents:
//   SNT/WNT/WT/ST  - 2-bit saturating predictor state encodings
//   bp_fsm_t       - branch state table sequencing states
//   bp_next_state  - saturating update of a predictor state by the actual outcome
package zap_branch_state_table_pkg;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_fsm_t;

   function automatic logic [1:0] bp_next_state(input logic [1:0] state, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (state == ST) ? ST : state + 2'd1;
      end else begin
         nxt = (state == SNT) ? SNT : state - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/zap_bp_ram.sv
// zap_bp_ram
// BP_ENTRIES x 2-bit predictor storage. One synchronous read port with read
// enable (the read register holds when the enable is low), one write port.
// No reset: the owner's initialisation sweep writes every entry.
// Ports:
//   i_clk    - clock
//   rd_en    - capture mem[rd_addr] into rd_data at the edge
//   rd_addr  - read index
//   rd_data  - registered read data (old value on a same-edge write)
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - write data
module zap_bp_ram #(
   parameter int BP_ENTRIES = 1024,
   parameter int IDX_W      = $clog2(BP_ENTRIES)
) (
   input  logic             i_clk,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [1:0]       rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [1:0]       wr_data
);

   logic [1:0] mem [BP_ENTRIES];

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/zap_branch_state_table.sv
// zap_branch_state_table
// Branch-history table of 2-bit saturating counters, read in lock-step with
// fetch and written back when the ALU resolves a branch. After reset an
// initialisation sweep sets every entry to WNT while o_bp_busy is high.
// Optional feature macro: BP_BYPASS_EN (forward a same-cycle update to the
// lookup of the same index).
// Ports:
//   i_clk, i_reset                      - clock, async active-high reset
//   i_clear_from_writeback              - flush, highest priority
//   i_data_stall                        - hold
//   i_clear_from_alu                    - flush
//   i_stall_from_shifter/issue/decode   - hold
//   i_fetch_pc, i_fetch_valid           - lookup request
//   i_br_update_valid/pc/state/taken    - resolved-branch write-back
//   o_taken_ff                          - predictor state entering predecode
//   o_bp_busy                           - initialisation sweep in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | sweep writes WNT to entry sweep_cnt, lookups return WNT,
//       | updates are dropped
// RUN   | lookups read the table, updates write the saturated next state
module zap_branch_state_table
   import zap_branch_state_table_pkg::*;
#(
   parameter int BP_ENTRIES = 1024,
   parameter int IDX_W      = $clog2(BP_ENTRIES)
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear_from_writeback,
   input  logic        i_data_stall,
   input  logic        i_clear_from_alu,
   input  logic        i_stall_from_shifter,
   input  logic        i_stall_from_issue,
   input  logic        i_stall_from_decode,
   input  logic [31:0] i_fetch_pc,
   input  logic        i_fetch_valid,
   input  logic        i_br_update_valid,
   input  logic [31:0] i_br_update_pc,
   input  logic [1:0]  i_br_update_state,
   input  logic        i_br_update_taken,
   output logic [1:0]  o_taken_ff,
   output logic        o_bp_busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BP_ENTRIES - 1);

   bp_fsm_t          state;
   logic [IDX_W-1:0] sweep_cnt;

   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [1:0]       upd_next;
   logic             in_run;
   logic             clr;
   logic             hold;
   logic             advance;
   logic             byp_hit;

   logic             ram_rd_en;
   logic [1:0]       ram_rd_data;
   logic             ram_wr_en;
   logic [IDX_W-1:0] ram_wr_addr;
   logic [1:0]       ram_wr_data;

   logic             use_ram;
   logic [1:0]       fix_q;

   // Halfword-aligned index; upper PC bits alias, bit 0 is ignored.
   assign fetch_idx = i_fetch_pc[IDX_W:1];
   assign upd_idx   = i_br_update_pc[IDX_W:1];
   assign upd_next  = bp_next_state(i_br_update_state, i_br_update_taken);
   assign in_run    = (state == RUN);

   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_fetch_pc[31:IDX_W+1], i_fetch_pc[0],
                             i_br_update_pc[31:IDX_W+1], i_br_update_pc[0]};

   // Predecode priority: writeback clear > data stall > alu clear > other stalls.
   assign clr     = i_clear_from_writeback | (~i_data_stall & i_clear_from_alu);
   assign hold    = ~i_clear_from_writeback &
                    (i_data_stall | i_stall_from_shifter |
                     i_stall_from_issue | i_stall_from_decode);
   assign advance = ~clr & ~hold;

`ifdef BP_BYPASS_EN
   assign byp_hit = in_run & i_br_update_valid & (upd_idx == fetch_idx);
`else
   assign byp_hit = 1'b0;
`endif

   assign ram_rd_en   = advance & i_fetch_valid & in_run & ~byp_hit;
   assign ram_wr_en   = ~in_run | i_br_update_valid;
   assign ram_wr_addr = in_run ? upd_idx : sweep_cnt;
   assign ram_wr_data = in_run ? upd_next : WNT;

   zap_bp_ram #(
      .BP_ENTRIES(BP_ENTRIES),
      .IDX_W     (IDX_W)
   ) u_ram (
      .i_clk  (i_clk),
      .rd_en  (ram_rd_en),
      .rd_addr(fetch_idx),
      .rd_data(ram_rd_data),
      .wr_en  (ram_wr_en),
      .wr_addr(ram_wr_addr),
      .wr_data(ram_wr_data)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= INIT;
         sweep_cnt <= '0;
         o_bp_busy <= 1'b1;
      end else if (state == INIT) begin
         o_bp_busy <= 1'b1;
         sweep_cnt <= sweep_cnt + IDX_W'(1);
         if (sweep_cnt == LAST_IDX) begin
            state <= RUN;
         end
      end else begin
         o_bp_busy <= 1'b0;
      end
   end

   // The RAM read register doubles as the output register for table hits;
   // fix_q carries every non-table value (clear, sweep WNT, bypass). Both
   // hold together on a stall, so the selected value is stable.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         use_ram <= 1'b0;
         fix_q   <= SNT;
      end else if (clr) begin
         use_ram <= 1'b0;
         fix_q   <= SNT;
      end else if (advance) begin
         if (!i_fetch_valid) begin
            use_ram <= 1'b0;
            fix_q   <= SNT;
         end else if (!in_run) begin
            use_ram <= 1'b0;
            fix_q   <= WNT;
         end else if (byp_hit) begin
            use_ram <= 1'b0;
            fix_q   <= upd_next;
         end else begin
            use_ram <= 1'b1;
         end
      end
   end

   assign o_taken_ff = use_ram ? ram_rd_data : fix_q;

endmodule
